// File: rtl/fft_frame_scheduler_if.sv
// Signal bundle between the frame scheduler and its ADC reader / SPI master neighbours.
// The scheduler attaches through the slave modport; the driving side uses master.
interface fft_frame_scheduler_if #(
    parameter int unsigned DATA_W = 16
);
    logic              i_Enable;
    logic              i_Clr_Ovr;
    logic              o_Sample;
    logic              i_ADC_DV;
    logic [DATA_W-1:0] i_ADC_Data;
    logic              o_TX_DV;
    logic [DATA_W-1:0] o_TX_Data;
    logic              i_TX_Ready;
    logic              o_Busy;
    logic              o_Overrun;
    logic [7:0]        o_Frame_Count;
    logic [1:0]        o_State;

    modport slave (
        input  i_Enable, i_Clr_Ovr, i_ADC_DV, i_ADC_Data, i_TX_Ready,
        output o_Sample, o_TX_DV, o_TX_Data, o_Busy, o_Overrun, o_Frame_Count, o_State
    );

    modport master (
        output i_Enable, i_Clr_Ovr, i_ADC_DV, i_ADC_Data, i_TX_Ready,
        input  o_Sample, o_TX_DV, o_TX_Data, o_Busy, o_Overrun, o_Frame_Count, o_State
    );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Paces ADC conversions, captures N samples into a frame buffer, then drains a header word
// plus the frame through the SPI master's DV/Ready handshake.
module fft_frame_scheduler #(
    parameter int unsigned N_SAMPLES  = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SAMPLE_DIV = 1600
) (
    input logic                  i_Clk,
    input logic                  i_Rst,
    fft_frame_scheduler_if.slave bus
);
    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned IDX_W  = $clog2(N_SAMPLES);
    localparam int unsigned WORD_W = $clog2(N_SAMPLES + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCapture = 2'b01,
        StDrain   = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                pending_q, pending_d;
    logic                outstanding_q, outstanding_d;
    logic                sample_q, sample_d;
    logic                tx_dv_q, tx_dv_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          frame_q, frame_d;
    logic [DATA_W-1:0]   frame_buf [N_SAMPLES];
    logic                buf_we;
    logic                tick;
    logic                ovr_set;
    logic [IDX_W-1:0]    rd_idx;

    assign tick   = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign rd_idx = IDX_W'(word_q - 1'b1);

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        wr_idx_d      = wr_idx_q;
        word_d        = word_q;
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        sample_d      = 1'b0;
        tx_dv_d       = 1'b0;
        tx_data_d     = tx_data_q;
        frame_d       = frame_q;
        buf_we        = 1'b0;
        ovr_set       = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_d     = '0;
                wr_idx_d  = '0;
                pending_d = 1'b0;
                if (bus.i_Enable) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (!bus.i_Enable) begin
                    state_d   = StIdle;
                    div_d     = '0;
                    wr_idx_d  = '0;
                    pending_d = 1'b0;
                end else begin
                    div_d = tick ? '0 : div_q + 1'b1;
                    if (tick) begin
                        if (pending_q) begin
                            ovr_set = 1'b1;
                        end else begin
                            sample_d  = 1'b1;
                            pending_d = 1'b1;
                        end
                    end
                    if (bus.i_ADC_DV && pending_q) begin
                        buf_we    = 1'b1;
                        pending_d = 1'b0;
                        wr_idx_d  = wr_idx_q + 1'b1;
                        if (wr_idx_q == IDX_W'(N_SAMPLES - 1)) begin
                            state_d       = StDrain;
                            wr_idx_d      = '0;
                            word_d        = '0;
                            outstanding_d = 1'b0;
                        end
                    end
                end
            end
            StDrain: begin
                // The divider keeps running so every slot lost to draining is flagged.
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    ovr_set = 1'b1;
                end
                if (outstanding_q) begin
                    if (!bus.i_TX_Ready) begin
                        outstanding_d = 1'b0;
                        if (word_q == WORD_W'(N_SAMPLES + 1)) begin
                            state_d   = bus.i_Enable ? StCapture : StIdle;
                            frame_d   = frame_q + 8'd1;
                            div_d     = '0;
                            wr_idx_d  = '0;
                            pending_d = 1'b0;
                            word_d    = '0;
                        end
                    end
                end else if (bus.i_TX_Ready && (word_q != WORD_W'(N_SAMPLES + 1))) begin
                    tx_dv_d       = 1'b1;
                    tx_data_d     = (word_q == '0) ? DATA_W'({8'hA5, frame_q}) : frame_buf[rd_idx];
                    word_d        = word_q + 1'b1;
                    outstanding_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Set has priority over a coincident clear.
        overrun_d = ovr_set ? 1'b1 : (bus.i_Clr_Ovr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q       <= StIdle;
            div_q         <= '0;
            wr_idx_q      <= '0;
            word_q        <= '0;
            pending_q     <= 1'b0;
            outstanding_q <= 1'b0;
            sample_q      <= 1'b0;
            tx_dv_q       <= 1'b0;
            tx_data_q     <= '0;
            overrun_q     <= 1'b0;
            frame_q       <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            wr_idx_q      <= wr_idx_d;
            word_q        <= word_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            sample_q      <= sample_d;
            tx_dv_q       <= tx_dv_d;
            tx_data_q     <= tx_data_d;
            overrun_q     <= overrun_d;
            frame_q       <= frame_d;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (buf_we) begin
            frame_buf[wr_idx_q] <= bus.i_ADC_Data;
        end
    end

    assign bus.o_Sample      = sample_q;
    assign bus.o_TX_DV       = tx_dv_q;
    assign bus.o_TX_Data     = tx_data_q;
    assign bus.o_Busy        = (state_q != StIdle);
    assign bus.o_Overrun     = overrun_q;
    assign bus.o_Frame_Count = frame_q;
    assign bus.o_State       = state_q;
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: ADC and SPI behavioural models, a sample scoreboard
// checked against drained words, and a table of frame scenarios plus corner sequences.
module tb_fft_frame_scheduler;
    localparam int unsigned N   = 8;
    localparam int unsigned DW  = 16;
    localparam int unsigned DIV = 16;

    typedef struct packed {
        int adc_delay;
        int spi_low;
        int gap;
        bit ovr_drain;
        bit ovr_end;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_frame_scheduler_if #(.DATA_W(DW)) bus ();

    fft_frame_scheduler #(
        .N_SAMPLES (N),
        .DATA_W    (DW),
        .SAMPLE_DIV(DIV)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus)
    );

    int n_pass = 0;
    int n_checks = 0;
    int cycle = 0;
    int adc_delay = 3;
    int spi_low = 20;
    int exp_gap = 16;
    int adc_cnt = 0;
    int low_cnt = 0;
    int pushes = 0;
    int sample_cnt = 0;
    int last_sample = -1;
    int widx = 0;
    int exp_frames = 0;
    int frames_rx = 0;
    int words_rx = 0;
    logic [15:0] adc_val = 16'h1000;
    logic [15:0] samp_q[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // ADC reader model: answers each o_Sample after adc_delay cycles, pushing the value.
    initial begin
        bus.i_ADC_DV = 1'b0;
        bus.i_ADC_Data = '0;
        forever begin
            @(posedge clk); #1;
            bus.i_ADC_DV = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    bus.i_ADC_DV = 1'b1;
                    bus.i_ADC_Data = adc_val;
                    samp_q.push_back(adc_val);
                    adc_val++;
                    pushes++;
                end
            end
            if (bus.o_Sample) begin
                sample_cnt++;
                if (last_sample >= 0) check("sample_gap", 32'(cycle - last_sample), 32'(exp_gap));
                last_sample = cycle;
                adc_cnt = adc_delay;
            end
        end
    end

    // SPI master model: drops Ready for spi_low cycles per word and scores each word.
    initial begin
        logic [15:0] exp_w;
        bus.i_TX_Ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bus.o_TX_DV) begin
                check("tx_ready_at_issue", 32'(bus.i_TX_Ready), 32'd1);
                if (widx == 0) begin
                    check("header", 32'(bus.o_TX_Data), 32'({8'hA5, 8'(exp_frames)}));
                end else begin
                    exp_w = (samp_q.size() > 0) ? samp_q.pop_front() : 16'hDEAD;
                    check("sample_word", 32'(bus.o_TX_Data), 32'(exp_w));
                end
                words_rx++;
                widx++;
                if (widx == N + 1) begin
                    widx = 0;
                    exp_frames++;
                    frames_rx++;
                    last_sample = -1;
                end
                bus.i_TX_Ready = 1'b0;
                low_cnt = spi_low;
            end else if (low_cnt > 0) begin
                low_cnt--;
                if (low_cnt == 0) bus.i_TX_Ready = 1'b1;
            end
        end
    end

    task automatic wait_state(input logic [1:0] st, input int budget);
        int n = 0;
        while (bus.o_State != st && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.o_State != st) begin
            n_checks++;
            $display("FAIL state_timeout: got %0d, expected %0d", bus.o_State, st);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_rx < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (frames_rx < target) begin
            n_checks++;
            $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_rx, target);
        end
    endtask

    task automatic flush_models();
        repeat (25) @(posedge clk);
        #1;
        samp_q.delete();
        adc_cnt = 0;
        last_sample = -1;
        sample_cnt = 0;
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        int f0;
        adc_delay = v.adc_delay;
        spi_low = v.spi_low;
        exp_gap = v.gap;
        sample_cnt = 0;
        last_sample = -1;
        bus.i_Enable = 1'b1;
        @(posedge clk); #1;
        check({nm, "_enter_capture"}, 32'(bus.o_State), 32'd1);
        f0 = frames_rx;
        wait_state(2'b10, 2000);
        check({nm, "_ovr_at_drain"}, 32'(bus.o_Overrun), 32'(v.ovr_drain));
        check({nm, "_sample_count"}, 32'(sample_cnt), 32'(N));
        wait_frames(f0 + 1, 5000);
        @(posedge clk); #1;
        check({nm, "_back_to_capture"}, 32'(bus.o_State), 32'd1);
        check({nm, "_busy"}, 32'(bus.o_Busy), 32'd1);
        check({nm, "_frame_count"}, 32'(bus.o_Frame_Count), 32'(8'(exp_frames)));
        check({nm, "_ovr_end"}, 32'(bus.o_Overrun), 32'(v.ovr_end));
        bus.i_Clr_Ovr = 1'b1;
        @(posedge clk); #1;
        bus.i_Clr_Ovr = 1'b0;
        @(posedge clk); #1;
        check({nm, "_ovr_cleared"}, 32'(bus.o_Overrun), 32'd0);
        bus.i_Enable = 1'b0;
        @(posedge clk); #1;
        check({nm, "_to_idle"}, 32'(bus.o_State), 32'd0);
        flush_models();
    endtask

    initial begin
        vec_t  vecs[3];
        string names[3];
        int    p0;
        int    w0;
        int    n;

        vecs[0] = '{adc_delay: 3,  spi_low: 20,  gap: 16, ovr_drain: 1'b0, ovr_end: 1'b1};
        vecs[1] = '{adc_delay: 20, spi_low: 20,  gap: 32, ovr_drain: 1'b1, ovr_end: 1'b1};
        vecs[2] = '{adc_delay: 3,  spi_low: 200, gap: 16, ovr_drain: 1'b0, ovr_end: 1'b1};
        names[0] = "nominal";
        names[1] = "slow_adc";
        names[2] = "slow_spi";

        rst = 1'b1;
        bus.i_Enable = 1'b0;
        bus.i_Clr_Ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(bus.o_State), 32'd0);
        check("rst_sample", 32'(bus.o_Sample), 32'd0);
        check("rst_tx_dv", 32'(bus.o_TX_DV), 32'd0);
        check("rst_tx_data", 32'(bus.o_TX_Data), 32'd0);
        check("rst_busy", 32'(bus.o_Busy), 32'd0);
        check("rst_overrun", 32'(bus.o_Overrun), 32'd0);
        check("rst_frame_count", 32'(bus.o_Frame_Count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) run_frame(vecs[i], names[i]);

        // Abort after five stored samples; the partial frame must vanish.
        adc_delay = 3;
        spi_low = 20;
        exp_gap = 16;
        p0 = pushes;
        w0 = words_rx;
        bus.i_Enable = 1'b1;
        n = 0;
        while (pushes < p0 + 5 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_five_samples", 32'(pushes - p0), 32'd5);
        @(posedge clk); #1;
        bus.i_Enable = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", 32'(bus.o_State), 32'd0);
        check("abort_frame_count", 32'(bus.o_Frame_Count), 32'(8'(exp_frames)));
        flush_models();
        check("abort_no_tx", 32'(words_rx), 32'(w0));
        run_frame(vecs[0], "restart");

        // Back-to-back frames through the count wrap; the final frame loses enable mid-drain.
        adc_delay = 3;
        spi_low = 2;
        exp_gap = 16;
        bus.i_Enable = 1'b1;
        wait_frames(256, 70000);
        wait_state(2'b10, 2000);
        bus.i_Enable = 1'b0;
        wait_frames(257, 2000);
        @(posedge clk); #1;
        check("drain_drop_idle", 32'(bus.o_State), 32'd0);
        check("wrap_frame_count", 32'(bus.o_Frame_Count), 32'd1);
        flush_models();

        // Reset while word 4 of a drain is in flight.
        spi_low = 20;
        bus.i_Enable = 1'b1;
        n = 0;
        while (!(widx == 4 && bus.o_State == 2'b10) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_word4", 32'(widx), 32'd4);
        rst = 1'b1;
        bus.i_Enable = 1'b0;
        @(posedge clk); #1;
        check("drain_rst_tx_dv", 32'(bus.o_TX_DV), 32'd0);
        check("drain_rst_tx_data", 32'(bus.o_TX_Data), 32'd0);
        check("drain_rst_state", 32'(bus.o_State), 32'd0);
        check("drain_rst_busy", 32'(bus.o_Busy), 32'd0);
        check("drain_rst_overrun", 32'(bus.o_Overrun), 32'd0);
        check("drain_rst_frame_count", 32'(bus.o_Frame_Count), 32'd0);
        rst = 1'b0;
        widx = 0;
        exp_frames = 0;
        flush_models();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
